// File: rtl/hsv_core_fetch_pkg.sv
// Fetch-queue sizing constants and pointer type.
package hsv_core_fetch_pkg;

  localparam int FETCH_QUEUE_DEPTH = 4;

  // One extra pointer bit distinguishes full from empty.
  localparam int FETCH_QUEUE_PTR_W = $clog2(FETCH_QUEUE_DEPTH) + 1;

  typedef logic [FETCH_QUEUE_PTR_W-1:0] fetch_queue_ptr_t;

endpackage

// File: rtl/hsv_core_pkg.sv
// Core-wide shared types used across pipeline stages.
package hsv_core_pkg;

  // One fetched instruction word as handed from fetch to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_increment;
    logic [31:0] insn;
  } fetch_data_t;

endpackage

// File: rtl/hsv_core_fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// slave is the queue side; master is the fetch/decode side.
interface hsv_core_fetch_queue_if
  import hsv_core_pkg::*, hsv_core_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) ();

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  fetch_data_t      in_data;
  logic             out_valid;
  logic             out_ready;
  fetch_data_t      out_data;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/hsv_core_fetch_queue_ram.sv
// Storage array for the fetch queue: one write port, one async read port,
// no reset (contents are don't-care until written).
module hsv_core_fetch_queue_ram
  import hsv_core_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  fetch_data_t       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output fetch_data_t       rdata
);

  fetch_data_t mem [DEPTH];

  // Write the selected entry on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hsv_core_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer with flush.
// Optional macro HSV_FETCH_QUEUE_BYPASS_EN lets a word pass straight from
// in_data to out_data when the queue is empty (zero-latency path).
module hsv_core_fetch_queue
  import hsv_core_pkg::*, hsv_core_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input logic                   clk_core,
  input logic                   rst_core,
  hsv_core_fetch_queue_if.slave q
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] occ;
  logic             full;
  logic             empty;
  logic             push_hs;
  logic             pop_hs;
  logic             do_write;
  logic             do_read;
  fetch_data_t      rdata;

  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == PTR_W'(DEPTH));
  assign empty = (occ == '0);

  // No out_ready term here: a full queue stalls a cycle even if it drains.
  assign q.in_ready  = !full && !q.flush && !rst_core;
  assign q.occupancy = rst_core ? '0 : OCC_W'(occ);

`ifdef HSV_FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass      = empty && q.in_valid && !q.flush && !rst_core;
  assign q.out_valid = (!empty || q.in_valid) && !q.flush && !rst_core;
  assign q.out_data  = empty ? q.in_data : rdata;
  assign push_hs     = q.in_valid && q.in_ready;
  assign pop_hs      = q.out_valid && q.out_ready;
  assign do_write    = push_hs && !(bypass && q.out_ready);
  assign do_read     = pop_hs && !empty;
`else
  assign q.out_valid = !empty && !q.flush && !rst_core;
  assign q.out_data  = rdata;
  assign push_hs     = q.in_valid && q.in_ready;
  assign pop_hs      = q.out_valid && q.out_ready;
  assign do_write    = push_hs;
  assign do_read     = pop_hs;
`endif

  // Pointer update: reset and flush both empty the queue, flush beats push/pop.
  always_ff @(posedge clk_core) begin
    if (rst_core || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  hsv_core_fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk_core),
    .we    (do_write),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (q.in_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_hsv_core_fetch_queue.sv
// Directed self-checking bench for hsv_core_fetch_queue.
// Define HSV_FETCH_QUEUE_BYPASS_EN for both RTL and bench to test the bypass build.
module tb_hsv_core_fetch_queue;
  import hsv_core_pkg::*;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  hsv_core_fetch_queue_if #(.DEPTH(4)) q ();

  hsv_core_fetch_queue #(.DEPTH(4)) dut (
    .clk_core (clk),
    .rst_core (rst),
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fetch_data_t mk(input logic [31:0] pc);
    fetch_data_t d;
    d.pc           = pc;
    d.pc_increment = 32'd4;
    d.insn         = pc + 32'h1000_0000;
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    q.in_valid  = iv;
    q.in_data   = mk(pc);
    q.out_ready = ordy;
    q.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pops;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst_in_ready", q.in_ready, 0);
    checkOutput("rst_out_valid", q.out_valid, 0);
    checkOutput("rst_occ", q.occupancy, 0);
    rst = 1'b0;
    step();
    checkOutput("post_rst_in_ready", q.in_ready, 1);

    // Basic fill with out_ready low, then drain in order
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("t1_occ1", q.occupancy, 1);
    checkOutput("t1_pc_a", q.out_data.pc, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
    step();
    checkOutput("t1_occ2", q.occupancy, 2);
    checkOutput("t1_pc_b", q.out_data.pc, 32'h0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
    step();
    checkOutput("t1_occ3", q.occupancy, 3);
    checkOutput("t1_pc_c", q.out_data.pc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("t1_drain0_valid", q.out_valid, 1);
    checkOutput("t1_drain0_pc", q.out_data.pc, 32'h0);
    step();
    checkOutput("t1_drain1_pc", q.out_data.pc, 32'h4);
    checkOutput("t1_drain1_occ", q.occupancy, 2);
    step();
    checkOutput("t1_drain2_pc", q.out_data.pc, 32'h8);
    step();
    checkOutput("t1_empty_valid", q.out_valid, 0);
    checkOutput("t1_empty_occ", q.occupancy, 0);

    // Full queue: in_ready low, and a pop cycle does not also accept a push
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4 * k), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("t2_full_in_ready", q.in_ready, 0);
    checkOutput("t2_full_occ", q.occupancy, 4);
    applyStimulus(1'b1, 32'h50, 1'b1, 1'b0);
    #1;
    checkOutput("t2_stall_in_ready", q.in_ready, 0);
    step();
    checkOutput("t2_after_pop_occ", q.occupancy, 3);
    checkOutput("t2_after_pop_in_ready", q.in_ready, 1);
    checkOutput("t2_after_pop_pc", q.out_data.pc, 32'h44);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("t2_drain_pc48", q.out_data.pc, 32'h48);
    step();
    checkOutput("t2_drain_pc4c", q.out_data.pc, 32'h4c);
    step();
    checkOutput("t2_drained_valid", q.out_valid, 0);
    checkOutput("t2_drained_occ", q.occupancy, 0);

    // Streaming 10 words through, crossing the pointer wrap
    pops = 0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (cyc < 10) applyStimulus(1'b1, 32'h100 + 32'(4 * cyc), 1'b1, 1'b0);
      else          applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      if (cyc < 10) checkOutput("t3_in_ready", q.in_ready, 1);
      if (q.out_valid) begin
        checkOutput("t3_insn", q.out_data.insn, 32'h1000_0100 + 32'(4 * pops));
        pops++;
      end
      step();
    end
    checkOutput("t3_pops", pops, 10);
    checkOutput("t3_occ", q.occupancy, 0);

    // Flush with a word offered: word dropped, queue emptied
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 32'h30c, 1'b0, 1'b1);
    #1;
    checkOutput("t4_flush_out_valid", q.out_valid, 0);
    checkOutput("t4_flush_in_ready", q.in_ready, 0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("t4_post_occ", q.occupancy, 0);
    checkOutput("t4_post_out_valid", q.out_valid, 0);
    checkOutput("t4_post_in_ready", q.in_ready, 1);
    applyStimulus(1'b1, 32'h310, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("t4_next_pc", q.out_data.pc, 32'h310);
    checkOutput("t4_next_occ", q.occupancy, 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("t4_empty_occ", q.occupancy, 0);

    // Reset mid-stream with two entries stored
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h404, 1'b0, 1'b0);
    step();
    checkOutput("t5_pre_occ", q.occupancy, 2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_in_ready", q.in_ready, 0);
    checkOutput("t5_rst_out_valid", q.out_valid, 0);
    checkOutput("t5_rst_occ", q.occupancy, 0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("t5_post_out_valid", q.out_valid, 0);
    checkOutput("t5_post_occ", q.occupancy, 0);
    checkOutput("t5_post_in_ready", q.in_ready, 1);

    // Push into an empty queue with out_ready high
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    #1;
`ifdef HSV_FETCH_QUEUE_BYPASS_EN
    checkOutput("t6_byp_valid", q.out_valid, 1);
    checkOutput("t6_byp_pc", q.out_data.pc, 32'h200);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("t6_byp_occ", q.occupancy, 0);
    checkOutput("t6_byp_after_valid", q.out_valid, 0);
`else
    checkOutput("t6_same_cycle_valid", q.out_valid, 0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("t6_next_valid", q.out_valid, 1);
    checkOutput("t6_next_pc", q.out_data.pc, 32'h200);
    checkOutput("t6_next_occ", q.occupancy, 1);
    step();
    checkOutput("t6_drained_occ", q.occupancy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
